pwm_apb_regs: RTL and testbench

APB3 register slave and tick generator sitting directly upstream of the 4-channel PWM core. It holds software-written shadow copies of each channel's EN/INV/PERIOD/DUTY and generates the PWM_CLKE prescaler tick. It copies all shadows into the active outputs in one cycle, aligned to a tick, so every channel changes coherently. Active outputs wire one-to-one to the matching PWM core inputs.

---
 rtl/pwm_apb_regs.sv | 190 +++++++++++++++++++
 tb/tb_pwm_apb_regs.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_apb_regs.sv
// APB3 register slave for the 4-channel PWM core: shadow registers,
// prescaler tick generator and tick-aligned shadow-to-active transfer.
module pwm_apb_regs #(
    parameter int ADDR_W = 8
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [ADDR_W-1:0] PADDR,
    input  logic [31:0]       PWDATA,
    output logic [31:0]       PRDATA,
    output logic              PREADY,
    output logic              PSLVERR,
    output logic              PWM_CLKE,
    output logic              PWM_EN0,
    output logic              PWM_EN1,
    output logic              PWM_EN2,
    output logic              PWM_EN3,
    output logic              PWM_INV0,
    output logic              PWM_INV1,
    output logic              PWM_INV2,
    output logic              PWM_INV3,
    output logic [15:0]       PWM_PERIOD0,
    output logic [15:0]       PWM_PERIOD1,
    output logic [15:0]       PWM_PERIOD2,
    output logic [15:0]       PWM_PERIOD3,
    output logic [15:0]       PWM_DUTY0,
    output logic [15:0]       PWM_DUTY1,
    output logic [15:0]       PWM_DUTY2,
    output logic [15:0]       PWM_DUTY3
);

    // Address split: region 0 is global control, regions 1..4 are channels 0..3
    logic [3:0]  region;
    logic [1:0]  sub;
    logic [1:0]  ch;
    logic        mapped;
    logic        access;
    logic        wr;
    logic        ctrl_wr;
    logic        upd_wr;
    logic        force_wr;
    logic        unused_bits;

    logic        presc_en;
    logic [15:0] presc;
    logic [15:0] cnt;
    logic        clke;
    logic        upd_pend;

    logic [3:0]  sh_en;
    logic [3:0]  sh_inv;
    logic [15:0] sh_period [4];
    logic [15:0] sh_duty   [4];
    logic [3:0]  act_en;
    logic [3:0]  act_inv;
    logic [15:0] act_period [4];
    logic [15:0] act_duty   [4];

    assign region   = PADDR[7:4];
    assign sub      = PADDR[3:2];
    assign ch       = region[1:0] - 2'd1;
    assign mapped   = (region <= 4'd4) && (sub != 2'd3);
    assign access   = PSEL & PENABLE;
    assign wr       = access & PWRITE & mapped;
    assign ctrl_wr  = wr && (region == 4'd0) && (sub == 2'd0);
    assign upd_wr   = ctrl_wr & PWDATA[1];
    assign force_wr = ctrl_wr & PWDATA[2];

    assign unused_bits = ^{PADDR, PWDATA};

    assign PREADY  = 1'b1;
    assign PSLVERR = access & ~mapped;

    // Software-visible control and shadow registers
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            presc_en  <= 1'b0;
            presc     <= '0;
            sh_en     <= '0;
            sh_inv    <= '0;
            sh_period <= '{default: '0};
            sh_duty   <= '{default: '0};
        end else if (wr) begin
            if (region == 4'd0) begin
                if (sub == 2'd0)
                    presc_en <= PWDATA[0];
                else if (sub == 2'd1)
                    presc <= PWDATA[15:0];
            end else begin
                case (sub)
                    2'd0: begin
                        sh_en[ch]  <= PWDATA[0];
                        sh_inv[ch] <= PWDATA[1];
                    end
                    2'd1:    sh_period[ch] <= PWDATA[15:0];
                    2'd2:    sh_duty[ch]   <= PWDATA[15:0];
                    default: ;
                endcase
            end
        end
    end

    // Prescaler: >= compare so a smaller PRESC wraps immediately
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt  <= '0;
            clke <= 1'b0;
        end else if (!presc_en) begin
            cnt  <= '0;
            clke <= 1'b0;
        end else if (cnt >= presc) begin
            cnt  <= '0;
            clke <= 1'b1;
        end else begin
            cnt  <= cnt + 16'd1;
            clke <= 1'b0;
        end
    end

    // Update engine: FORCE loads now, UPDATE waits for a registered tick.
    // Pending is tested before the new write, so an UPDATE landing on a tick
    // only arms the transfer for the following tick.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            upd_pend   <= 1'b0;
            act_en     <= '0;
            act_inv    <= '0;
            act_period <= '{default: '0};
            act_duty   <= '{default: '0};
        end else begin
            if (force_wr || (upd_pend && clke)) begin
                act_en     <= sh_en;
                act_inv    <= sh_inv;
                act_period <= sh_period;
                act_duty   <= sh_duty;
            end
            if (force_wr)
                upd_pend <= 1'b0;
            else if (upd_pend) begin
                if (clke)
                    upd_pend <= 1'b0;
            end else if (upd_wr)
                upd_pend <= 1'b1;
        end
    end

    // Read mux: shadows only, zero for unmapped or idle bus
    always_comb begin
        PRDATA = '0;
        if (PSEL && mapped) begin
            if (region == 4'd0) begin
                case (sub)
                    2'd0:    PRDATA = {29'd0, 1'b0, upd_pend, presc_en};
                    2'd1:    PRDATA = {16'd0, presc};
                    2'd2:    PRDATA = {31'd0, upd_pend};
                    default: PRDATA = '0;
                endcase
            end else begin
                case (sub)
                    2'd0:    PRDATA = {30'd0, sh_inv[ch], sh_en[ch]};
                    2'd1:    PRDATA = {16'd0, sh_period[ch]};
                    2'd2:    PRDATA = {16'd0, sh_duty[ch]};
                    default: PRDATA = '0;
                endcase
            end
        end
    end

    assign PWM_CLKE    = clke;
    assign PWM_EN0     = act_en[0];
    assign PWM_EN1     = act_en[1];
    assign PWM_EN2     = act_en[2];
    assign PWM_EN3     = act_en[3];
    assign PWM_INV0    = act_inv[0];
    assign PWM_INV1    = act_inv[1];
    assign PWM_INV2    = act_inv[2];
    assign PWM_INV3    = act_inv[3];
    assign PWM_PERIOD0 = act_period[0];
    assign PWM_PERIOD1 = act_period[1];
    assign PWM_PERIOD2 = act_period[2];
    assign PWM_PERIOD3 = act_period[3];
    assign PWM_DUTY0   = act_duty[0];
    assign PWM_DUTY1   = act_duty[1];
    assign PWM_DUTY2   = act_duty[2];
    assign PWM_DUTY3   = act_duty[3];

endmodule

// File: tb/tb_pwm_apb_regs.sv
// Directed self-checking bench for pwm_apb_regs.
module tb_pwm_apb_regs;

    logic        CLK;
    logic        RST_N;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [7:0]  PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;
    logic        PWM_CLKE;
    logic        PWM_EN0, PWM_EN1, PWM_EN2, PWM_EN3;
    logic        PWM_INV0, PWM_INV1, PWM_INV2, PWM_INV3;
    logic [15:0] PWM_PERIOD0, PWM_PERIOD1, PWM_PERIOD2, PWM_PERIOD3;
    logic [15:0] PWM_DUTY0, PWM_DUTY1, PWM_DUTY2, PWM_DUTY3;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int e0;

    logic [31:0] rd;
    logic        er;

    pwm_apb_regs #(.ADDR_W(8)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
        .PREADY(PREADY), .PSLVERR(PSLVERR), .PWM_CLKE(PWM_CLKE),
        .PWM_EN0(PWM_EN0), .PWM_EN1(PWM_EN1), .PWM_EN2(PWM_EN2), .PWM_EN3(PWM_EN3),
        .PWM_INV0(PWM_INV0), .PWM_INV1(PWM_INV1), .PWM_INV2(PWM_INV2), .PWM_INV3(PWM_INV3),
        .PWM_PERIOD0(PWM_PERIOD0), .PWM_PERIOD1(PWM_PERIOD1),
        .PWM_PERIOD2(PWM_PERIOD2), .PWM_PERIOD3(PWM_PERIOD3),
        .PWM_DUTY0(PWM_DUTY0), .PWM_DUTY1(PWM_DUTY1),
        .PWM_DUTY2(PWM_DUTY2), .PWM_DUTY3(PWM_DUTY3)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Commit edge is the third posedge after the call; returns 1 time unit after it
    task automatic apb_write(input logic [7:0] a, input logic [31:0] d);
        @(posedge CLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = a; PWDATA = d;
        @(posedge CLK); #1;
        PENABLE = 1'b1;
        @(posedge CLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic apb_read(input logic [7:0] a, output logic [31:0] d, output logic e);
        @(posedge CLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = a;
        @(posedge CLK); #1;
        PENABLE = 1'b1;
        #2;
        d = PRDATA;
        e = PSLVERR;
        @(posedge CLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    task automatic read_check(input string tag, input logic [7:0] a, input logic [31:0] exp);
        logic [31:0] d;
        logic        e;
        apb_read(a, d, e);
        check(tag, d, exp);
    endtask

    // Advance to 1 time unit after posedge number t
    task automatic goto(input int t);
        while (cyc < t) begin
            @(posedge CLK); #1;
        end
    endtask

    logic [7:0] maps [15] = '{8'h00, 8'h04, 8'h08, 8'h10, 8'h14, 8'h18, 8'h20, 8'h24,
                              8'h28, 8'h30, 8'h34, 8'h38, 8'h40, 8'h44, 8'h48};
    logic [7:0] unmaps [4] = '{8'h0C, 8'h1C, 8'h4C, 8'h80};

    initial begin
        RST_N = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        PADDR = '0; PWDATA = '0;
        #23 RST_N = 1'b1;
        @(posedge CLK); #1;

        // Reset state
        check("rst_clke", {31'd0, PWM_CLKE}, 32'd0);
        check("rst_pready", {31'd0, PREADY}, 32'd1);
        check("rst_en_inv", {24'd0, PWM_EN3, PWM_EN2, PWM_EN1, PWM_EN0,
                             PWM_INV3, PWM_INV2, PWM_INV1, PWM_INV0}, 32'd0);
        check("rst_per01", {PWM_PERIOD1, PWM_PERIOD0}, 32'd0);
        check("rst_per23", {PWM_PERIOD3, PWM_PERIOD2}, 32'd0);
        check("rst_duty01", {PWM_DUTY1, PWM_DUTY0}, 32'd0);
        check("rst_duty23", {PWM_DUTY3, PWM_DUTY2}, 32'd0);
        foreach (maps[i]) begin
            apb_read(maps[i], rd, er);
            check($sformatf("rst_rd_%h", maps[i]), rd, 32'd0);
            check($sformatf("rst_err_%h", maps[i]), {31'd0, er}, 32'd0);
        end
        foreach (unmaps[i]) begin
            apb_read(unmaps[i], rd, er);
            check($sformatf("unmap_rd_%h", unmaps[i]), rd, 32'd0);
            check($sformatf("unmap_err_%h", unmaps[i]), {31'd0, er}, 32'd1);
        end

        // Prescaler: PRESC=3 ticks on the 4th edge after enable, then every 4
        apb_write(8'h04, 32'd3);
        read_check("presc_rd", 8'h04, 32'd3);
        apb_write(8'h00, 32'd1);
        for (int i = 1; i <= 8; i++) begin
            @(posedge CLK); #1;
            check($sformatf("p3_clke_%0d", i), {31'd0, PWM_CLKE}, {31'd0, (i % 4) == 0});
        end
        apb_write(8'h04, 32'd0);
        for (int i = 1; i <= 4; i++) begin
            @(posedge CLK); #1;
            check($sformatf("p0_clke_%0d", i), {31'd0, PWM_CLKE}, 32'd1);
        end
        // PRESC=7 resets CNT to 0; back-to-back PRESC=1 commits while CNT=3
        apb_write(8'h04, 32'd7);
        apb_write(8'h04, 32'd1);
        for (int i = 1; i <= 6; i++) begin
            @(posedge CLK); #1;
            check($sformatf("p1_clke_%0d", i), {31'd0, PWM_CLKE}, {31'd0, (i % 2) == 1});
        end

        // Tick-aligned UPDATE of channel 2 with PRESC=9
        apb_write(8'h00, 32'd0);
        apb_write(8'h34, 32'd100);
        apb_write(8'h38, 32'd25);
        apb_write(8'h30, 32'd3);
        apb_write(8'h04, 32'd9);
        read_check("sh_per2", 8'h34, 32'd100);
        read_check("sh_ctl2", 8'h30, 32'd3);
        apb_write(8'h00, 32'd1);
        e0 = cyc;
        apb_write(8'h00, 32'd3);
        check("upd_hold_en2", {31'd0, PWM_EN2}, 32'd0);
        read_check("upd_status_pend", 8'h08, 32'd1);
        read_check("upd_ctrl_rd", 8'h00, 32'd3);
        goto(e0 + 10);
        check("upd_tick", {31'd0, PWM_CLKE}, 32'd1);
        check("upd_hold_per2", {16'd0, PWM_PERIOD2}, 32'd0);
        goto(e0 + 11);
        check("upd_per2", {16'd0, PWM_PERIOD2}, 32'd100);
        check("upd_duty2", {16'd0, PWM_DUTY2}, 32'd25);
        check("upd_en_inv2", {30'd0, PWM_INV2, PWM_EN2}, 32'd3);
        read_check("upd_status_clr", 8'h08, 32'd0);

        // UPDATE committing on a tick edge transfers only on the next tick
        apb_write(8'h24, 32'h1234);
        goto(e0 + 18);
        apb_write(8'h00, 32'd3);
        check("late_clke_low", {31'd0, PWM_CLKE}, 32'd0);
        goto(e0 + 30);
        check("late_tick", {31'd0, PWM_CLKE}, 32'd1);
        check("late_hold_per1", {16'd0, PWM_PERIOD1}, 32'd0);
        goto(e0 + 31);
        check("late_per1", {16'd0, PWM_PERIOD1}, 32'h1234);

        // Shadow write on the transfer edge: active gets the old shadow
        apb_write(8'h18, 32'h11);
        apb_write(8'h00, 32'd3);
        goto(e0 + 38);
        apb_write(8'h18, 32'h22);
        check("coinc_duty0", {16'd0, PWM_DUTY0}, 32'h11);
        read_check("coinc_sh_duty0", 8'h18, 32'h22);
        apb_write(8'h00, 32'd3);
        goto(e0 + 50);
        check("coinc_hold_duty0", {16'd0, PWM_DUTY0}, 32'h11);
        goto(e0 + 51);
        check("coinc_new_duty0", {16'd0, PWM_DUTY0}, 32'h22);

        // Prescaler off: UPDATE pends forever, FORCE loads at once
        apb_write(8'h44, 32'hBEEF);
        apb_write(8'h00, 32'd2);
        goto(e0 + 90);
        check("off_clke", {31'd0, PWM_CLKE}, 32'd0);
        check("off_hold_per3", {16'd0, PWM_PERIOD3}, 32'd0);
        read_check("off_status_pend", 8'h08, 32'd1);
        apb_write(8'h00, 32'd4);
        check("force_per3", {16'd0, PWM_PERIOD3}, 32'hBEEF);
        read_check("force_status", 8'h08, 32'd0);

        // Unmapped write is ignored and errors
        apb_write(8'h1C, 32'hFFFF);
        apb_read(8'h1C, rd, er);
        check("unmap_wr_rd", rd, 32'd0);
        check("unmap_wr_err", {31'd0, er}, 32'd1);
        read_check("unmap_wr_duty0", 8'h18, 32'h22);

        // Asynchronous reset while pending clears everything
        apb_write(8'h00, 32'd2);
        read_check("pre_rst_pend", 8'h08, 32'd1);
        @(posedge CLK); #3;
        RST_N = 1'b0;
        #1;
        check("arst_en_inv", {24'd0, PWM_EN3, PWM_EN2, PWM_EN1, PWM_EN0,
                              PWM_INV3, PWM_INV2, PWM_INV1, PWM_INV0}, 32'd0);
        check("arst_per23", {PWM_PERIOD3, PWM_PERIOD2}, 32'd0);
        check("arst_duty01", {PWM_DUTY1, PWM_DUTY0}, 32'd0);
        check("arst_per1", {16'd0, PWM_PERIOD1}, 32'd0);
        #10 RST_N = 1'b1;
        @(posedge CLK); #1;
        read_check("arst_status", 8'h08, 32'd0);
        read_check("arst_sh_duty0", 8'h18, 32'd0);
        repeat (12) @(posedge CLK);
        #1;
        check("arst_no_xfer_per3", {16'd0, PWM_PERIOD3}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
